// File: rtl/sl2apb_pkg.sv
// Shared types for the serial-link-to-APB initiator: FSM states, command and response records.
package sl2apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  // Command records carry the widest supported address; users slice to their ADDR_WIDTH.
  localparam int unsigned MaxAddrWidth = 32;

  typedef struct packed {
    logic                    write;
    logic [MaxAddrWidth-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              strb;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  // Reads never carry byte strobes on the bus.
  function automatic logic [3:0] apb_strb(input logic write, input logic [3:0] strb);
    return write ? strb : 4'b0000;
  endfunction

endpackage

// File: rtl/sl2apb_initiator_if.sv
// Command/response handshakes plus APB4 initiator bus. The master modport is the initiator's
// view; the slave modport is the surrounding link logic and APB target.
interface sl2apb_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic                  pready;
  logic                  pslverr;
  logic [31:0]           prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );

endinterface

// File: rtl/sl2apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the cycle whose count would reach limit.
module sl2apb_timeout_cnt (
  input  logic        pclk,
  input  logic        preset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Fires in the stalled cycle whose increment would make the count equal the limit.
  assign expired = enable && (({1'b0, cnt_q} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/sl2apb_initiator.sv
// APB4 initiator: one command in, one SETUP/ACCESS transfer out, one response back.
// Optional ACCESS watchdog enabled by defining SL2APB_TIMEOUT_EN.
module sl2apb_initiator
  import sl2apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                pclk,
  input logic                preset,
  sl2apb_initiator_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || ADDR_WIDTH < 1 || ADDR_WIDTH > 32)
  begin : g_bad_params
    $error("sl2apb_initiator: illegal TIMEOUT_CYCLES or ADDR_WIDTH");
  end

  state_e                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]           pwdata_q;
  logic [3:0]            pstrb_q;
  logic                  rsp_valid_q;
  rsp_t                  rsp_q;
  logic                  timeout_hit;

`ifdef SL2APB_TIMEOUT_EN
  sl2apb_timeout_cnt u_timeout_cnt (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !bus.pready),
    .limit   (16'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
            pstrb_q  <= apb_strb(bus.cmd_write, bus.cmd_strb);
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a coincident timeout.
          if (bus.pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : 32'd0;
            rsp_q.err     <= bus.pslverr;
            rsp_q.timeout <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_q.rdata   <= 32'd0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_sl2apb_initiator.sv
// Directed bench for sl2apb_initiator; timeout cases run only when SL2APB_TIMEOUT_EN is defined.
module tb_sl2apb_initiator;
  import sl2apb_pkg::*;

  localparam int unsigned AddrWidth = 10;

  localparam cmd_t WrData = '{write: 1'b1, addr: 32'd5, wdata: 32'hA5A5_1234, strb: 4'hF};
  localparam cmd_t RdStat = '{write: 1'b0, addr: 32'd7, wdata: 32'h1111_2222, strb: 4'hF};
  localparam cmd_t RdBad  = '{write: 1'b0, addr: 32'd9, wdata: 32'h0,         strb: 4'h0};
  localparam cmd_t WrCfg  = '{write: 1'b1, addr: 32'd6, wdata: 32'h0000_0011, strb: 4'h3};
  localparam cmd_t RdData = '{write: 1'b0, addr: 32'd5, wdata: 32'h0,         strb: 4'h0};

  logic        pclk = 1'b0;
  logic        preset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 pclk = ~pclk;

  sl2apb_initiator_if #(.ADDR_WIDTH(AddrWidth)) bus ();

  sl2apb_initiator #(
    .ADDR_WIDTH     (AddrWidth),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; all drives and samples happen there.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input cmd_t c);
    bus.cmd_write = c.write;
    bus.cmd_addr  = c.addr[AddrWidth-1:0];
    bus.cmd_wdata = c.wdata;
    bus.cmd_strb  = c.strb;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic check_apb(input string tag, input logic psel, input logic penable);
    check_eq({tag, ".psel"}, 32'(bus.psel), 32'(psel));
    check_eq({tag, ".penable"}, 32'(bus.penable), 32'(penable));
  endtask

  task automatic check_rsp(input string tag, input logic valid, input logic [31:0] rdata,
                           input logic err, input logic tmo);
    check_eq({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(valid));
    check_eq({tag, ".rsp_rdata"}, bus.rsp_rdata, rdata);
    check_eq({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(err));
    check_eq({tag, ".rsp_timeout"}, 32'(bus.rsp_timeout), 32'(tmo));
  endtask

  initial begin
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b1;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    step();
    step();

    // Reset state
    check_eq("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_apb("rst", 1'b0, 1'b0);
    check_eq("rst.pwrite", 32'(bus.pwrite), 32'd0);
    check_eq("rst.paddr", 32'(bus.paddr), 32'd0);
    check_eq("rst.pwdata", bus.pwdata, 32'd0);
    check_eq("rst.pstrb", 32'(bus.pstrb), 32'd0);
    check_rsp("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    preset = 1'b0;
    step();

    // Zero-wait write
    drive_cmd(WrData);
    check_eq("wr.N.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    check_apb("wr.N1", 1'b1, 1'b0);
    check_eq("wr.N1.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("wr.paddr", 32'(bus.paddr), 32'd5);
    check_eq("wr.pwrite", 32'(bus.pwrite), 32'd1);
    check_eq("wr.pwdata", bus.pwdata, 32'hA5A5_1234);
    check_eq("wr.pstrb", 32'(bus.pstrb), 32'hF);
    step();
    check_apb("wr.N2", 1'b1, 1'b1);
    check_eq("wr.N2.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    check_apb("wr.N3", 1'b0, 1'b0);
    check_rsp("wr.N3", 1'b1, 32'd0, 1'b0, 1'b0);
    step();
    check_eq("wr.N4.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("wr.N4.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("wr.N4.pwdata_held", bus.pwdata, 32'hA5A5_1234);

    // Read with three wait states; strobes masked to zero
    bus.pready = 1'b0;
    drive_cmd(RdStat);
    step();
    bus.cmd_valid = 1'b0;
    check_apb("rd.N1", 1'b1, 1'b0);
    check_eq("rd.pstrb", 32'(bus.pstrb), 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      check_apb("rd.wait", 1'b1, 1'b1);
      check_eq("rd.wait.paddr", 32'(bus.paddr), 32'd7);
      check_eq("rd.wait.pwrite", 32'(bus.pwrite), 32'd0);
      check_eq("rd.wait.pstrb", 32'(bus.pstrb), 32'h0);
      check_eq("rd.wait.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_00C3;
    check_apb("rd.N5", 1'b1, 1'b1);
    step();
    bus.prdata = 32'h0;
    check_apb("rd.N6", 1'b0, 1'b0);
    check_rsp("rd.N6", 1'b1, 32'h0000_00C3, 1'b0, 1'b0);
    step();

    // Read answered with pslverr
    drive_cmd(RdBad);
    step();
    bus.cmd_valid = 1'b0;
    check_eq("err.paddr", 32'(bus.paddr), 32'd9);
    step();
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hDEAD_BEEF;
    step();
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    check_rsp("err.N3", 1'b1, 32'd0, 1'b1, 1'b0);
    step();

    // Response back-pressure with the next command already waiting
    drive_cmd(WrCfg);
    step();
    bus.cmd_valid = 1'b0;
    step();
    bus.pslverr = 1'b1;
    step();
    bus.pslverr   = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_cmd(RdData);
    for (int i = 0; i < 5; i++) begin
      check_rsp("bp.hold", 1'b1, 32'd0, 1'b1, 1'b0);
      check_eq("bp.hold.cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("bp.hold.psel", 32'(bus.psel), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    check_eq("bp.N8.cmd_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    check_eq("bp.N9.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("bp.N9.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("bp.N9.psel", 32'(bus.psel), 32'd0);
    step();
    bus.cmd_valid = 1'b0;
    bus.prdata    = 32'h55AA_0001;
    check_apb("bp.N10", 1'b1, 1'b0);
    check_eq("bp.N10.paddr", 32'(bus.paddr), 32'd5);
    check_eq("bp.N10.pwrite", 32'(bus.pwrite), 32'd0);
    step();
    check_apb("bp.N11", 1'b1, 1'b1);
    step();
    check_rsp("bp.N12", 1'b1, 32'h55AA_0001, 1'b0, 1'b0);
    step();
    bus.prdata = 32'h0;
    check_eq("bp.N13.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Asynchronous reset in ACCESS
    bus.pready = 1'b0;
    drive_cmd(RdStat);
    step();
    bus.cmd_valid = 1'b0;
    step();
    check_apb("ar.access", 1'b1, 1'b1);
    #3;
    preset = 1'b1;
    #1;
    check_apb("ar.async", 1'b0, 1'b0);
    check_eq("ar.async.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("ar.async.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("ar.async.paddr", 32'(bus.paddr), 32'd0);
    #1;
    preset     = 1'b0;
    bus.pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("ar.after.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("ar.after.psel", 32'(bus.psel), 32'd0);
      check_eq("ar.after.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end

`ifdef SL2APB_TIMEOUT_EN
    // Timeout abort after four stalled ACCESS cycles
    bus.pready = 1'b0;
    bus.prdata = 32'h1234_5678;
    drive_cmd(RdData);
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check_apb("to.access", 1'b1, 1'b1);
      check_eq("to.access.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    check_apb("to.abort", 1'b0, 1'b0);
    check_rsp("to.abort", 1'b1, 32'd0, 1'b1, 1'b1);
    step();

    // pready in the fourth ACCESS cycle beats the timeout
    drive_cmd(RdData);
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) step();
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_ABCD;
    check_apb("tr.access4", 1'b1, 1'b1);
    step();
    check_rsp("tr.done", 1'b1, 32'h0000_ABCD, 1'b0, 1'b0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
